huffman_ctrl: RTL and testbench
===============================

HUFFMAN_CTRL -- requirements
Module: huffman_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port gray_valid, input, 1 bit: symbol stream qualifier; a frame is one contiguous high run.
REQ-004 SHALL have port gray_data, input, 8 bits: symbol value, sampled when gray_valid=1.
REQ-005 SHALL have port CNT_valid, output, 1 bit: one-cycle pulse when CNT1..CNT6 are final for the frame.
REQ-006 SHALL have ports CNT1..CNT6, outputs, 8 bits each: occurrence counts of symbols 1..6.
REQ-007 SHALL have port eng_start, output, 1 bit: one-cycle request to the shared sort/merge engine.
REQ-008 SHALL have port eng_stage, output, 3 bits: index of the last active entry for the current stage (5..1); held stable from eng_start until eng_done.
REQ-009 SHALL have port eng_done, input, 1 bit: engine completion pulse for the current stage.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port code_valid, output, 1 bit: one-cycle pulse when all five stages are complete.

Function
REQ-012 SHALL implement the states IDLE, COUNT, REPORT, ISSUE, WAIT and FINISH.
REQ-013 IDLE->COUNT: on gray_valid=1, clear CNT1..CNT6 and count that first symbol in the same edge.
REQ-014 COUNT: on each cycle with gray_valid=1 and gray_data=k (1..6), CNTk SHALL increment by 1, saturating at 255.
REQ-015 COUNT: gray_data of 0 or 7..255 SHALL not change any count.
REQ-016 COUNT->REPORT: on the first cycle with gray_valid=0; REPORT asserts CNT_valid for exactly one cycle.
REQ-017 Latency: gray_valid falls at edge t -> CNT_valid high in cycle t+1 -> eng_start high in cycle t+2 with eng_stage=5.
REQ-018 REPORT->ISSUE->WAIT: ISSUE asserts eng_start for one cycle, then the FSM enters WAIT.
REQ-019 eng_done SHALL be sampled only in WAIT; earliest acceptance is the cycle after eng_start; eng_done in any other state is ignored.
REQ-020 WAIT with eng_done=1 and eng_stage>1: eng_stage decrements by 1 and the FSM goes to ISSUE (next start one cycle after done).
REQ-021 WAIT with eng_done=1 and eng_stage=1: go to FINISH, which asserts code_valid for one cycle, then return to IDLE.
REQ-022 gray_valid SHALL be ignored in REPORT, ISSUE, WAIT and FINISH; counts do not change and no new frame starts.
REQ-023 CNT1..CNT6 SHALL hold their values from REPORT until the next frame starts in IDLE.
REQ-024 gray_valid=1 in the FINISH cycle SHALL be ignored; a new frame starts only when gray_valid=1 while in IDLE.
REQ-025 WAIT SHALL have no timeout; the FSM waits indefinitely for eng_done.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE and set CNT1..CNT6=0, eng_stage=5, and CNT_valid, eng_start, busy, code_valid=0.
REQ-027 Reset asserted mid-frame or mid-stage SHALL abandon the operation; after release, no stale eng_start or code_valid is issued.

Configuration
REQ-028 Macro HUFF_CTRL_ERR_CNT_EN defined: add output err_cnt (8 bits, saturating at 255) that counts out-of-range symbols (0, 7..255) within a frame, cleared at frame start and at reset, valid with CNT_valid.
REQ-029 Macro HUFF_CTRL_ERR_CNT_EN undefined: no err_cnt port and no related logic; all other behaviour is identical.

Verification
REQ-030 Frame 1,2,2,3,3,3,4,5,6,6 then gray_valid=0 -> CNT1..CNT6=1,2,3,1,1,2; CNT_valid one cycle later; eng_start the next cycle with eng_stage=5.
REQ-031 Engine responds with eng_done 1 cycle after each start -> eng_stage sequence 5,4,3,2,1; code_valid exactly 1 cycle after the 5th done; busy=0 afterwards.
REQ-032 300 consecutive symbols of value 4 -> CNT4=255 (saturated), all other counts 0.
REQ-033 Frame 0,7,200,1 -> CNT1=1, other counts 0; with HUFF_CTRL_ERR_CNT_EN defined, err_cnt=3.
REQ-034 gray_valid pulses and a spurious eng_done during the stage-3 wait and in IDLE -> counts unchanged; eng_stage advances only on eng_done in WAIT.
REQ-035 reset pulse while eng_stage=2 -> all outputs at reset values; a following frame completes normally starting at eng_stage=5.

Source files
------------

// File: rtl/huffman_ctrl.sv
// rtl/huffman_ctrl.sv - symbol-frame counter and five-stage sort/merge engine sequencer.
// Optional build macro HUFF_CTRL_ERR_CNT_EN adds the err_cnt output.
module huffman_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       gray_valid,
    input  logic [7:0] gray_data,
    output logic       CNT_valid,
    output logic [7:0] CNT1,
    output logic [7:0] CNT2,
    output logic [7:0] CNT3,
    output logic [7:0] CNT4,
    output logic [7:0] CNT5,
    output logic [7:0] CNT6,
    output logic       eng_start,
    output logic [2:0] eng_stage,
    input  logic       eng_done,
    output logic       busy,
`ifdef HUFF_CTRL_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       code_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        REPORT = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [2:0] FIRST_STAGE = 3'd5;

    state_t          state_q, state_d;
    logic [5:0][7:0] cnt_q, cnt_d;
    logic [2:0]      stage_q, stage_d;
    logic            cnt_valid_q, cnt_valid_d;
    logic            eng_start_q, eng_start_d;
    logic            busy_q, busy_d;
    logic            code_valid_q, code_valid_d;
`ifdef HUFF_CTRL_ERR_CNT_EN
    logic [7:0]      err_q, err_d;
`endif

    logic            sym_ok;
    logic [2:0]      sym_idx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign sym_ok  = (gray_data >= 8'd1) && (gray_data <= 8'd6);
    assign sym_idx = gray_data[2:0] - 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
`ifdef HUFF_CTRL_ERR_CNT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (gray_valid) begin
                    // The first symbol of a frame is counted on the same edge that clears the totals.
                    cnt_d = '0;
                    if (sym_ok) begin
                        cnt_d[sym_idx] = 8'd1;
                    end
`ifdef HUFF_CTRL_ERR_CNT_EN
                    err_d = sym_ok ? 8'd0 : 8'd1;
`endif
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (gray_valid) begin
                    if (sym_ok) begin
                        cnt_d[sym_idx] = sat_inc(cnt_q[sym_idx]);
                    end
`ifdef HUFF_CTRL_ERR_CNT_EN
                    else begin
                        err_d = sat_inc(err_q);
                    end
`endif
                end else begin
                    state_d = REPORT;
                end
            end
            REPORT: state_d = ISSUE;
            ISSUE:  state_d = WAIT;
            WAIT: begin
                if (eng_done) begin
                    if (stage_q == 3'd1) begin
                        state_d = FINISH;
                    end else begin
                        stage_d = stage_q - 3'd1;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                stage_d = FIRST_STAGE;
                state_d = IDLE;
            end
            default: begin
                stage_d = FIRST_STAGE;
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        cnt_valid_d  = (state_d == REPORT);
        eng_start_d  = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        code_valid_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stage_q      <= FIRST_STAGE;
            cnt_valid_q  <= 1'b0;
            eng_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            code_valid_q <= 1'b0;
`ifdef HUFF_CTRL_ERR_CNT_EN
            err_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            cnt_valid_q  <= cnt_valid_d;
            eng_start_q  <= eng_start_d;
            busy_q       <= busy_d;
            code_valid_q <= code_valid_d;
`ifdef HUFF_CTRL_ERR_CNT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign CNT1       = cnt_q[0];
    assign CNT2       = cnt_q[1];
    assign CNT3       = cnt_q[2];
    assign CNT4       = cnt_q[3];
    assign CNT5       = cnt_q[4];
    assign CNT6       = cnt_q[5];
    assign CNT_valid  = cnt_valid_q;
    assign eng_start  = eng_start_q;
    assign eng_stage  = stage_q;
    assign busy       = busy_q;
    assign code_valid = code_valid_q;
`ifdef HUFF_CTRL_ERR_CNT_EN
    assign err_cnt    = err_q;
`endif

endmodule

// File: tb/tb_huffman_ctrl.sv
// tb/tb_huffman_ctrl.sv - directed bench for huffman_ctrl with a behavioural per-cycle model.
module tb_huffman_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gray_valid = 1'b0;
    logic [7:0] gray_data = 8'd0;
    logic       eng_done = 1'b0;
    logic       CNT_valid, eng_start, busy, code_valid;
    logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
    logic [2:0] eng_stage;
`ifdef HUFF_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int q[$];

    huffman_ctrl dut (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .CNT_valid(CNT_valid), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4),
        .CNT5(CNT5), .CNT6(CNT6), .eng_start(eng_start), .eng_stage(eng_stage),
        .eng_done(eng_done), .busy(busy),
`ifdef HUFF_CTRL_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .code_valid(code_valid)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 collecting, 2 report, 3 start request, 4 waiting, 5 finished.
    int m_phase;
    int m_cnt[1:6];
    int m_err;
    int m_stage;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_stage = 5;
            m_err = 0;
            for (int k = 1; k <= 6; k++) m_cnt[k] = 0;
        end else begin
            int v;
            v = int'(gray_data);
            if (m_phase == 0 && gray_valid) begin
                for (int k = 1; k <= 6; k++) m_cnt[k] = 0;
                m_err = 0;
                m_phase = 1;
            end else if (m_phase == 1 && !gray_valid) begin
                m_phase = 2;
                v = -1;
            end else if (m_phase == 1) begin
                v = v;
            end else begin
                v = -1;
                if (m_phase == 2) m_phase = 3;
                else if (m_phase == 3) m_phase = 4;
                else if (m_phase == 4 && eng_done) begin
                    if (m_stage == 1) m_phase = 5;
                    else begin
                        m_stage = m_stage - 1;
                        m_phase = 3;
                    end
                end else if (m_phase == 5) begin
                    m_phase = 0;
                    m_stage = 5;
                end
            end
            if (v >= 1 && v <= 6) m_cnt[v] = (m_cnt[v] >= 255) ? 255 : m_cnt[v] + 1;
            else if (v >= 0) m_err = (m_err >= 255) ? 255 : m_err + 1;
        end
    end

    always @(negedge clk) begin
        logic ok;
        ok = (CNT_valid == (m_phase == 2)) && (eng_start == (m_phase == 3)) &&
             (busy == (m_phase != 0)) && (code_valid == (m_phase == 5)) &&
             (int'(eng_stage) == m_stage) &&
             (int'(CNT1) == m_cnt[1]) && (int'(CNT2) == m_cnt[2]) && (int'(CNT3) == m_cnt[3]) &&
             (int'(CNT4) == m_cnt[4]) && (int'(CNT5) == m_cnt[5]) && (int'(CNT6) == m_cnt[6]);
`ifdef HUFF_CTRL_ERR_CNT_EN
        if (int'(err_cnt) != m_err) ok = 1'b0;
`endif
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL model_cycle t=%0t act cv=%b st=%b stg=%0d busy=%b cd=%b cnt=%0d,%0d,%0d,%0d,%0d,%0d exp phase=%0d stg=%0d cnt=%0d,%0d,%0d,%0d,%0d,%0d",
                     $time, CNT_valid, eng_start, eng_stage, busy, code_valid,
                     CNT1, CNT2, CNT3, CNT4, CNT5, CNT6, m_phase, m_stage,
                     m_cnt[1], m_cnt[2], m_cnt[3], m_cnt[4], m_cnt[5], m_cnt[6]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_q();
        foreach (q[i]) begin
            gray_valid = 1'b1;
            gray_data = q[i][7:0];
            tick();
        end
        gray_valid = 1'b0;
        gray_data = 8'd0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20; i++) begin
            if (eng_start) return;
            tick();
        end
        chk("eng_start_timeout", 0, 1);
    endtask

    task automatic stage_step(input int s, input int lat, input bit noise);
        wait_start();
        chk("eng_stage_at_start", int'(eng_stage), s);
        if (noise && s == 3) begin
            eng_done = 1'b1;
            gray_valid = 1'b1;
            gray_data = 8'd2;
        end
        tick();
        eng_done = 1'b0;
        for (int i = 1; i < lat; i++) begin
            if (noise && s == 3) gray_valid = i[0];
            tick();
        end
        gray_valid = 1'b0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    task automatic run_stages(input int lat, input bit noise);
        for (int s = 5; s >= 1; s--) stage_step(s, lat, noise);
        chk("code_valid_after_last_done", int'(code_valid), 1);
        tick();
        chk("code_valid_one_cycle", int'(code_valid), 0);
        chk("busy_after_finish", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_stage", int'(eng_stage), 5);
        chk("reset_cnt_valid", int'(CNT_valid), 0);
        chk("reset_cnt1", int'(CNT1), 0);
        tick();

        // Basic frame and latency chain
        q = '{1, 2, 2, 3, 3, 3, 4, 5, 6, 6};
        send_q();
        tick();
        chk("frame1_cnt_valid", int'(CNT_valid), 1);
        chk("frame1_cnt1", int'(CNT1), 1);
        chk("frame1_cnt2", int'(CNT2), 2);
        chk("frame1_cnt3", int'(CNT3), 3);
        chk("frame1_cnt4", int'(CNT4), 1);
        chk("frame1_cnt5", int'(CNT5), 1);
        chk("frame1_cnt6", int'(CNT6), 2);
        tick();
        chk("frame1_cnt_valid_drop", int'(CNT_valid), 0);
        chk("frame1_eng_start", int'(eng_start), 1);
        chk("frame1_stage5", int'(eng_stage), 5);
        run_stages(1, 1'b0);
        chk("frame1_cnt3_held", int'(CNT3), 3);

        // Spurious done in IDLE, then noisy stage-3 wait
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("idle_done_ignored_busy", int'(busy), 0);
        chk("idle_done_ignored_stage", int'(eng_stage), 5);
        q = '{1, 1};
        send_q();
        run_stages(3, 1'b1);
        chk("noise_cnt1", int'(CNT1), 2);
        chk("noise_cnt2", int'(CNT2), 0);

        // Saturation
        q.delete();
        for (int i = 0; i < 300; i++) q.push_back(4);
        send_q();
        tick();
        chk("sat_cnt4", int'(CNT4), 255);
        chk("sat_cnt1", int'(CNT1), 0);
        chk("sat_cnt6", int'(CNT6), 0);
        run_stages(2, 1'b0);

        // Out-of-range symbols
        q = '{0, 7, 200, 1};
        send_q();
        tick();
        chk("oor_cnt1", int'(CNT1), 1);
        chk("oor_cnt2", int'(CNT2), 0);
        chk("oor_cnt4", int'(CNT4), 0);
`ifdef HUFF_CTRL_ERR_CNT_EN
        chk("oor_err_cnt", int'(err_cnt), 3);
`endif
        run_stages(1, 1'b0);

        // Reset during stage 2
        q = '{6};
        send_q();
        for (int s = 5; s >= 3; s--) stage_step(s, 1, 1'b0);
        wait_start();
        chk("pre_reset_stage2", int'(eng_stage), 2);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_stage", int'(eng_stage), 5);
        chk("mid_reset_cnt6", int'(CNT6), 0);
        chk("mid_reset_start", int'(eng_start), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("post_reset_no_start", int'(eng_start), 0);
            chk("post_reset_no_code", int'(code_valid), 0);
            tick();
        end
        q = '{3, 3};
        send_q();
        run_stages(1, 1'b0);
        chk("post_reset_cnt3", int'(CNT3), 2);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
